mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: max consecutive data grants while fetch waits.
REQ-002 SHALL have parameter MEM_AW, default 16: address/data width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port if_req  in  1  fetch read request; held until if_done.
REQ-006 SHALL have port if_addr  in  16  fetch address (PC).
REQ-007 SHALL have port if_done  out  1  one-cycle pulse, fetch data valid.
REQ-008 SHALL have port if_rdata  out  16  registered fetch read data.
REQ-009 SHALL have port d_req  in  1  data request from memory stage; held until d_done.
REQ-010 SHALL have port d_wr  in  1  1=store, 0=load.
REQ-011 SHALL have port d_addr  in  16  data address (execute ALU result).
REQ-012 SHALL have port d_wdata  in  16  store data.
REQ-013 SHALL have port d_done  out  1  one-cycle pulse, data access complete.
REQ-014 SHALL have port d_rdata  out  16  registered load data.
REQ-015 SHALL have port mem_en  out  1  memory access active.
REQ-016 SHALL have port mem_wr  out  1  memory write strobe.
REQ-017 SHALL have port mem_addr  out  16  memory address.
REQ-018 SHALL have port mem_wdata  out  16  memory write data.
REQ-019 SHALL have port mem_rdata  in  16  memory read data, valid with mem_done.
REQ-020 SHALL have port mem_done  in  1  memory completion, 1..N cycles after mem_en rises.
REQ-021 SHALL have port stall_fetch  out  1  = if_req & ~if_done.
REQ-022 SHALL have port stall_mem  out  1  = d_req & ~d_done.

Function
REQ-023 SHALL implement FSM states IDLE, BUSY_I, BUSY_D.
REQ-024 IDLE: eligible data (d_req & ~d_done) and (no eligible fetch or starve_cnt < STARVE_LIMIT) -> BUSY_D; else eligible fetch (if_req & ~if_done) -> BUSY_I; else stay IDLE.
REQ-025 On grant, mem_addr/mem_wr/mem_wdata SHALL be registered from the granted requester (fetch: mem_wr=0, mem_wdata=0) and held constant through the BUSY state.
REQ-026 mem_en SHALL be 1 exactly while in BUSY_I or BUSY_D; mem_wr SHALL be 1 only in BUSY_D with latched d_wr=1.
REQ-027 BUSY_x with mem_done=1 -> IDLE; x_done SHALL pulse the following cycle, with x_rdata = mem_rdata captured at mem_done (d_rdata unchanged on stores).
REQ-028 Minimum transaction: grant cycle, one BUSY cycle with mem_done, done cycle in IDLE = 3 cycles from req to done.
REQ-029 A requester SHALL be ineligible in the cycle its done is high (prevents regrant of a held request).
REQ-030 starve_cnt (2-bit min, saturating at STARVE_LIMIT) SHALL increment on each D grant when an eligible fetch is pending, and clear on I grant or whenever if_req=0.
REQ-031 mem_done in IDLE SHALL be ignored.
REQ-032 Requester deasserting req mid-transaction: transaction completes, done still pulses.
REQ-033 x_rdata SHALL hold its last value until the next completion for that requester.

Reset
REQ-034 rst_n low SHALL asynchronously force state=IDLE, mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0, if_done=0, d_done=0, if_rdata=0, d_rdata=0, starve_cnt=0.
REQ-035 Reset mid-transaction SHALL abort it with no done pulse; first grant possible in first clock edge after rst_n rises.

Structure
REQ-036 FSM state encodings and STARVE_LIMIT default SHALL live in the shared CPU package/header.
REQ-037 SHALL be a single module, no sub-modules; one FSM block, one datapath register block, combinational stall outputs.

Verification
REQ-038 Fetch only, if_addr=0x0040, mem_done 1 cycle after mem_en, mem_rdata=0xA5A5 -> mem_addr=0x0040, mem_wr=0, if_done pulse cycle 3, if_rdata=0xA5A5.
REQ-039 Simultaneous if_req and d_req (store 0x1234 to 0x0100) -> D granted first, mem_wr=1, mem_wdata=0x1234, d_done; I granted next, if_done.
REQ-040 d_req held through 4 back-to-back loads with if_req pending -> exactly 3 D grants, then I grant, then D resumes.
REQ-041 mem_done delayed 5 cycles -> mem_en high 6 cycles, mem_addr stable, stall_mem high until d_done.
REQ-042 rst_n low during BUSY_D -> mem_en=0 immediately, no d_done, state IDLE after release.
REQ-043 mem_done=1 while IDLE, no requests -> no done pulse, rdata registers unchanged.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM state
// encodings, default parameters and a width helper for the starvation counter.
// Imported by mem_arbiter; holds no logic of its own.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_e;

    // Max consecutive data grants allowed while a fetch is waiting.
    localparam int STARVE_LIMIT_DEF = 3;
    // Address / data width of both requesters and the memory port.
    localparam int MEM_AW_DEF       = 16;

    // Starvation counter width: enough to hold the limit, never below 2 bits.
    function automatic int starve_cnt_w(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 2) ? 2 : w;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between instruction fetch and data (load/store) requests.
// Latency: request to done pulse is grant cycle + memory busy cycles + done cycle (3 minimum).
// Backpressure: requests are held until their done pulse; stall_* flag waiting requesters.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   if_req/if_addr -> if_done/if_rdata fetch read channel
//   d_req/d_wr/d_addr/d_wdata -> d_done/d_rdata   data channel
//   mem_en/mem_wr/mem_addr/mem_wdata, mem_rdata/mem_done   memory port
//   stall_fetch, stall_mem             combinational pipeline stall outputs
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int MEM_AW       = MEM_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [MEM_AW-1:0] if_addr,
    output logic              if_done,
    output logic [MEM_AW-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [MEM_AW-1:0] d_addr,
    input  logic [MEM_AW-1:0] d_wdata,
    output logic              d_done,
    output logic [MEM_AW-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [MEM_AW-1:0] mem_wdata,
    input  logic [MEM_AW-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              stall_fetch,
    output logic              stall_mem
);

    localparam int             SCW        = starve_cnt_w(STARVE_LIMIT);
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

    arb_state_e        state_q;
    logic [SCW-1:0]    starve_cnt_q, starve_cnt_d;
    logic              if_done_q, d_done_q, mem_en_q, mem_wr_q;
    logic [MEM_AW-1:0] mem_addr_q, mem_wdata_q, if_rdata_q, d_rdata_q;

    logic if_elig, d_elig, grant_d, grant_i, busy_done;

    // A requester whose done is high this cycle is still holding its old
    // request, so it must not be granted again.
    always_comb begin
        if_elig   = if_req & ~if_done_q;
        d_elig    = d_req & ~d_done_q;
        grant_d   = (state_q == ST_IDLE) && d_elig &&
                    (!if_elig || (starve_cnt_q < STARVE_MAX));
        grant_i   = (state_q == ST_IDLE) && !grant_d && if_elig;
        busy_done = (state_q != ST_IDLE) && mem_done;

        starve_cnt_d = starve_cnt_q;
        if (!if_req || grant_i) begin
            starve_cnt_d = '0;
        end else if (grant_d && if_elig && (starve_cnt_q < STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + SCW'(1);
        end
    end

    // Control FSM: state, memory enable, done pulses and fairness counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            mem_en_q     <= 1'b0;
            if_done_q    <= 1'b0;
            d_done_q     <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            if_done_q    <= 1'b0;
            d_done_q     <= 1'b0;
            starve_cnt_q <= starve_cnt_d;
            case (state_q)
                ST_IDLE: begin
                    // mem_done seen here belongs to nobody and is ignored.
                    if (grant_d) begin
                        state_q  <= ST_BUSY_D;
                        mem_en_q <= 1'b1;
                    end else if (grant_i) begin
                        state_q  <= ST_BUSY_I;
                        mem_en_q <= 1'b1;
                    end
                end
                ST_BUSY_I: begin
                    if (mem_done) begin
                        state_q   <= ST_IDLE;
                        mem_en_q  <= 1'b0;
                        if_done_q <= 1'b1;
                    end
                end
                ST_BUSY_D: begin
                    if (mem_done) begin
                        state_q  <= ST_IDLE;
                        mem_en_q <= 1'b0;
                        d_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    mem_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: command latched at grant and held for the whole access;
    // read data captured on completion (stores leave d_rdata untouched).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if (grant_d) begin
                mem_addr_q  <= d_addr;
                mem_wdata_q <= d_wdata;
                mem_wr_q    <= d_wr;
            end else if (grant_i) begin
                mem_addr_q  <= if_addr;
                mem_wdata_q <= '0;
                mem_wr_q    <= 1'b0;
            end else if (busy_done) begin
                mem_wr_q    <= 1'b0;
            end
            if ((state_q == ST_BUSY_I) && mem_done) begin
                if_rdata_q <= mem_rdata;
            end
            if ((state_q == ST_BUSY_D) && mem_done && !mem_wr_q) begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

    assign if_done     = if_done_q;
    assign d_done      = d_done_q;
    assign if_rdata    = if_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign mem_en      = mem_en_q;
    assign mem_wr      = mem_wr_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign stall_fetch = if_req & ~if_done_q;
    assign stall_mem   = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// requesters, checked every cycle against a transaction-level reference.
// A behavioural memory array supplies read data with per-access latency.
module tb_mem_arbiter;

    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_wr, mem_done;
    logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_done, d_done, mem_en, mem_wr, stall_fetch, stall_mem;
    logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    int tests = 0;
    int fails = 0;

    // Reference state
    logic [15:0] mem [256];
    bit          own_d;
    logic [15:0] cur_addr, cur_wdata;
    logic        cur_wr;
    logic [15:0] exp_if_rdata, exp_d_rdata, rd_val;
    int          streak, drun, max_drun, i_grants, d_grants;
    int          en_cnt, lat, fixed_lat;
    bit          noise;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(LIMIT), .MEM_AW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done),
        .stall_fetch(stall_fetch), .stall_mem(stall_mem)
    );

    task automatic chk1(input string tag, input logic obs, input logic want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, want);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    // Memory: completes the k-th cycle that mem_en is high, k = latency.
    task automatic mem_model();
        logic [7:0] idx;
        if (mem_en) begin
            if (en_cnt == 0) lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
            en_cnt++;
            if (en_cnt == lat) begin
                idx      = mem_addr[7:0];
                mem_done = 1'b1;
                if (mem_wr) begin
                    mem[idx]  = mem_wdata;
                    mem_rdata = 16'($urandom);
                end else begin
                    mem_rdata = mem[idx];
                end
                rd_val = mem_rdata;
            end else begin
                mem_done  = 1'b0;
                mem_rdata = 16'($urandom);
            end
        end else begin
            en_cnt    = 0;
            mem_done  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = 16'($urandom);
        end
    endtask

    // One clock: snapshot what the arbiter saw, advance, check against the rules.
    task automatic tick();
        bit          p_if_elig, p_d_elig, p_if_req, p_mem_en, p_mem_done, p_d_wr;
        bit          grant, gd, want_en;
        logic [15:0] p_if_addr, p_d_addr, p_d_wdata;
        p_if_elig  = if_req && !if_done;
        p_d_elig   = d_req && !d_done;
        p_if_req   = if_req;
        p_mem_en   = mem_en;
        p_mem_done = mem_done;
        p_if_addr  = if_addr;
        p_d_addr   = d_addr;
        p_d_wr     = d_wr;
        p_d_wdata  = d_wdata;
        gd         = 1'b0;
        @(posedge clk);
        #1;
        // completion of the access in flight
        chk1("if_done", if_done, p_mem_en && p_mem_done && !own_d);
        chk1("d_done", d_done, p_mem_en && p_mem_done && own_d);
        if (p_mem_en && p_mem_done) begin
            if (!own_d) exp_if_rdata = rd_val;
            else if (!cur_wr) exp_d_rdata = rd_val;
        end
        chk16("if_rdata", if_rdata, exp_if_rdata);
        chk16("d_rdata", d_rdata, exp_d_rdata);
        // arbitration
        grant   = !p_mem_en && (p_if_elig || p_d_elig);
        want_en = p_mem_en ? !p_mem_done : grant;
        chk1("mem_en", mem_en, want_en);
        if (grant) begin
            gd        = p_d_elig && (!p_if_elig || streak < LIMIT);
            own_d     = gd;
            cur_addr  = gd ? p_d_addr : p_if_addr;
            cur_wr    = gd ? p_d_wr : 1'b0;
            cur_wdata = gd ? p_d_wdata : 16'h0000;
            if (gd) begin
                d_grants++;
                if (p_if_elig) drun++;
            end else begin
                i_grants++;
                drun = 0;
            end
            if (drun > max_drun) max_drun = drun;
        end
        if (!p_if_req) begin
            streak = 0;
            drun   = 0;
        end else if (grant && !gd) begin
            streak = 0;
        end else if (grant && gd && p_if_elig && streak < LIMIT) begin
            streak++;
        end
        if (mem_en) begin
            chk16("mem_addr", mem_addr, cur_addr);
            chk1("mem_wr", mem_wr, cur_wr);
            chk16("mem_wdata", mem_wdata, cur_wdata);
        end else begin
            chk1("mem_wr_idle", mem_wr, 1'b0);
        end
        chk1("stall_fetch", stall_fetch, if_req && !if_done);
        chk1("stall_mem", stall_mem, d_req && !d_done);
        mem_model();
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        if_req   = 1'b0;
        d_req    = 1'b0;
        mem_done = 1'b0;
        #1;
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_mem_wr", mem_wr, 1'b0);
        chk16("rst_mem_addr", mem_addr, 16'h0000);
        chk16("rst_mem_wdata", mem_wdata, 16'h0000);
        chk1("rst_if_done", if_done, 1'b0);
        chk1("rst_d_done", d_done, 1'b0);
        chk16("rst_if_rdata", if_rdata, 16'h0000);
        chk16("rst_d_rdata", d_rdata, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        own_d        = 1'b0;
        en_cnt       = 0;
        exp_if_rdata = 16'h0000;
        exp_d_rdata  = 16'h0000;
        streak       = 0;
        drun         = 0;
        rst_n        = 1'b1;
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && (mem_en || if_done || d_done); n++) tick();
        chk1("drain_idle", mem_en, 1'b0);
    endtask

    task automatic agents();
        if (if_req && if_done) begin
            if ($urandom_range(0, 1) == 1) if_addr = 16'($urandom_range(0, 31));
            else if_req = 1'b0;
        end else if (!if_req) begin
            if ($urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = 16'($urandom_range(0, 31));
            end
        end else if ($urandom_range(0, 31) == 0) begin
            if_req = 1'b0;
        end
        if (d_req && d_done) begin
            if ($urandom_range(0, 1) == 1) begin
                d_wr    = 1'($urandom_range(0, 1));
                d_addr  = 16'($urandom_range(0, 31));
                d_wdata = 16'($urandom);
            end else begin
                d_req = 1'b0;
            end
        end else if (!d_req) begin
            if ($urandom_range(0, 2) == 0) begin
                d_req   = 1'b1;
                d_wr    = 1'($urandom_range(0, 1));
                d_addr  = 16'($urandom_range(0, 31));
                d_wdata = 16'($urandom);
            end
        end else if ($urandom_range(0, 31) == 0) begin
            d_req = 1'b0;
        end
    endtask

    initial begin
        int nd, gi0, en_cycles;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_wr = 1'b0; mem_rdata = '0;
        fixed_lat = 1; noise = 1'b0; rd_val = '0;
        cur_addr = '0; cur_wdata = '0; cur_wr = 1'b0;
        max_drun = 0; i_grants = 0; d_grants = 0; lat = 1;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);

        // Reset state
        apply_reset();

        // Single fetch, one-cycle memory
        mem[8'h40] = 16'hA5A5;
        if_req = 1'b1; if_addr = 16'h0040;
        tick();
        chk16("t_fetch_addr", mem_addr, 16'h0040);
        chk1("t_fetch_wr", mem_wr, 1'b0);
        chk1("t_fetch_nodone_c2", if_done, 1'b0);
        tick();
        chk1("t_fetch_done_c3", if_done, 1'b1);
        chk16("t_fetch_rdata", if_rdata, 16'hA5A5);
        if_req = 1'b0;
        drain();

        // Simultaneous fetch and store: data first, fetch in the done cycle
        if_req = 1'b1; if_addr = 16'h0202;
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'h1234;
        tick();
        chk1("t_both_wr", mem_wr, 1'b1);
        chk16("t_both_wdata", mem_wdata, 16'h1234);
        chk16("t_both_addr", mem_addr, 16'h0100);
        tick();
        chk1("t_both_d_done", d_done, 1'b1);
        d_req = 1'b0;
        tick();
        chk16("t_both_i_addr", mem_addr, 16'h0202);
        tick();
        chk1("t_both_i_done", if_done, 1'b1);
        if_req = 1'b0;
        drain();
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0100;
        tick();
        tick();
        chk1("t_reload_done", d_done, 1'b1);
        chk16("t_reload_rdata", d_rdata, 16'h1234);
        d_req = 1'b0;
        drain();

        // Held data requests with a pending fetch: fetch must get served
        if_req = 1'b1; if_addr = 16'h0003;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0010;
        nd = 0; gi0 = i_grants; max_drun = 0;
        for (int c = 0; c < 80 && nd < 4; c++) begin
            tick();
            if (if_done) if_addr = if_addr + 16'd1;
            if (d_done) begin
                nd++;
                d_addr = d_addr + 16'd1;
                if (nd == 4) d_req = 1'b0;
            end
        end
        chk1("t_starve_loads", nd == 4, 1'b1);
        chk1("t_starve_fetch_served", i_grants > gi0, 1'b1);
        chk1("t_starve_bound", max_drun <= LIMIT, 1'b1);
        if_req = 1'b0;
        drain();

        // Slow memory: completion on the sixth enabled cycle
        fixed_lat = 6;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0042;
        en_cycles = 0;
        for (int c = 0; c < 20 && !d_done; c++) begin
            tick();
            if (mem_en) en_cycles++;
            if (!d_done) chk1("t_slow_stall_mem", stall_mem, 1'b1);
        end
        chk1("t_slow_done", d_done, 1'b1);
        chk1("t_slow_en_len", en_cycles == 6, 1'b1);
        d_req = 1'b0;
        drain();

        // Reset in the middle of a store
        fixed_lat = 5;
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0077; d_wdata = 16'hBEEF;
        tick();
        tick();
        chk1("t_abort_busy", mem_en, 1'b1);
        #2;
        apply_reset();
        if_req = 1'b1; if_addr = 16'h0055;
        tick();
        chk1("t_abort_first_grant", mem_en, 1'b1);
        chk1("t_abort_no_d_done", d_done, 1'b0);
        if_req = 1'b0;
        drain();

        // Stray mem_done while idle
        fixed_lat = 1;
        noise = 1'b1;
        repeat (8) tick();
        chk1("t_stray_if_done", if_done, 1'b0);
        chk1("t_stray_d_done", d_done, 1'b0);

        // Random traffic, random latency, stray completions while idle
        fixed_lat = 0;
        max_drun = 0;
        for (int c = 0; c < 1500; c++) begin
            tick();
            agents();
        end
        if_req = 1'b0;
        d_req = 1'b0;
        drain();
        chk1("t_rand_starve_bound", max_drun <= LIMIT, 1'b1);
        chk1("t_rand_both_served", (i_grants > 20) && (d_grants > 20), 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
